// File: rtl/mem_port_arbiter.sv
// Arbiter that lets the fetch port and the data port share one single-port synchronous RAM.
// Data wins by default. A saturating starvation counter forces a fetch grant after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_inst_req,
  input  logic [ADDR_WIDTH-1:0] i_inst_addr,
  output logic                  o_inst_gnt,
  output logic                  o_inst_rvalid,
  output logic [DATA_WIDTH-1:0] o_inst_rdata,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic                  o_data_gnt,
  output logic                  o_data_rvalid,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;

  typedef struct packed {
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
  } inst_req_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } data_req_t;

  inst_req_t             ireq;
  data_req_t             dreq;
  owner_e                rd_owner;
  owner_e                owner_nxt;
  logic [CW-1:0]         starve_cnt;
  logic                  force_inst;
  logic                  inst_gnt;
  logic                  data_gnt;
  logic                  inst_rvalid;
  logic                  data_rvalid;
  logic [DATA_WIDTH-1:0] inst_hold;
  logic [DATA_WIDTH-1:0] data_hold;

  assign ireq = '{req: i_inst_req, addr: i_inst_addr};
  assign dreq = '{req: i_data_req, we: i_data_we, addr: i_data_addr, wdata: i_data_wdata};

  // Grants are gated by reset so the RAM is never touched while the block is held in reset.
  always_comb begin
    force_inst = (starve_cnt == CW'(STARVE_LIMIT));
    inst_gnt   = !i_rst && ireq.req && (!dreq.req || force_inst);
    data_gnt   = !i_rst && dreq.req && !inst_gnt;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (inst_gnt)                 owner_nxt = OWN_INST;
    else if (data_gnt && !dreq.we) owner_nxt = OWN_DATA;
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (inst_gnt)      o_mem_addr = ireq.addr;
    else if (data_gnt) o_mem_addr = dreq.addr;
    if (data_gnt && dreq.we) o_mem_wdata = dreq.wdata;
  end

  assign o_inst_gnt = inst_gnt;
  assign o_data_gnt = data_gnt;
  assign o_mem_en   = inst_gnt | data_gnt;
  assign o_mem_we   = data_gnt & dreq.we;

  // Read-owner FSM; the rvalid flops are registered copies of the owner decode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_owner    <= OWN_NONE;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
    end else begin
      rd_owner    <= owner_nxt;
      inst_rvalid <= (owner_nxt == OWN_INST);
      data_rvalid <= (owner_nxt == OWN_DATA);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (inst_gnt || !ireq.req) begin
      starve_cnt <= '0;
    end else if (!force_inst) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Capture the returned word so the port keeps seeing it after rvalid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      if (inst_rvalid) inst_hold <= i_mem_rdata;
      if (data_rvalid) data_hold <= i_mem_rdata;
    end
  end

  // The RAM word is live during the return cycle, so bypass it onto the port then.
  assign o_inst_rvalid = inst_rvalid && (rd_owner == OWN_INST);
  assign o_data_rvalid = data_rvalid && (rd_owner == OWN_DATA);
  assign o_inst_rdata  = o_inst_rvalid ? i_mem_rdata : inst_hold;
  assign o_data_rdata  = o_data_rvalid ? i_mem_rdata : data_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a RAM model and a per-port read-return scoreboard.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_gnt, inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt, data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram    [1024];
  logic [DW-1:0] shadow [1024];
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr), .o_inst_gnt(inst_gnt),
    .o_inst_rvalid(inst_rvalid), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_we(data_we), .i_data_addr(data_addr),
    .i_data_wdata(data_wdata), .o_data_gnt(data_gnt),
    .o_data_rvalid(data_rvalid), .o_data_rdata(data_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every read grant must return exactly one cycle later on its own port.
  always @(negedge clk) begin
    if (rst) begin
      iq.delete();
      dq.delete();
    end else begin
      chk("sb_inst_rvalid", {63'd0, inst_rvalid}, {63'd0, iq.size() > 0});
      if (inst_rvalid && iq.size() > 0) chk("sb_inst_rdata", inst_rdata, iq.pop_front());
      chk("sb_data_rvalid", {63'd0, data_rvalid}, {63'd0, dq.size() > 0});
      if (data_rvalid && dq.size() > 0) chk("sb_data_rdata", data_rdata, dq.pop_front());
      chk("sb_gnt_onehot", {63'd0, inst_gnt & data_gnt}, 64'd0);
      chk("sb_mem_en", {63'd0, mem_en}, {63'd0, inst_gnt | data_gnt});
      if (inst_gnt) begin
        chk("sb_inst_addr", mem_addr, inst_addr);
        iq.push_back(shadow[inst_addr]);
      end
      if (data_gnt) begin
        chk("sb_data_addr", mem_addr, data_addr);
        chk("sb_mem_we", {63'd0, mem_we}, {63'd0, data_we});
        if (data_we) shadow[data_addr] = data_wdata;
        else         dq.push_back(shadow[data_addr]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = 32'hC0DE_0000 | i;
      shadow[i] = 32'hC0DE_0000 | i;
    end
    ram[4]    = 32'h0000_0013;
    shadow[4] = 32'h0000_0013;

    // Reset with both requests pending
    #1;
    rst = 1'b1; inst_req = 1'b1; inst_addr = 10'h004; data_req = 1'b1; data_addr = 10'h010;
    cyc();
    chk("rst_inst_gnt", inst_gnt, 0);
    chk("rst_data_gnt", data_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_inst_rvalid", inst_rvalid, 0);
    chk("rst_data_rvalid", data_rvalid, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    cyc();
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    cyc();
    chk("idle_mem_addr", mem_addr, 0);

    // Fetch only
    inst_req = 1'b1; inst_addr = 10'h004; #1;
    chk("f_inst_gnt", inst_gnt, 1);
    chk("f_data_gnt", data_gnt, 0);
    chk("f_mem_addr", mem_addr, 10'h004);
    cyc();
    inst_req = 1'b0; #1;
    chk("f_inst_rvalid", inst_rvalid, 1);
    chk("f_inst_rdata", inst_rdata, 32'h0000_0013);
    cyc();
    chk("f_inst_rvalid_drop", inst_rvalid, 0);
    chk("f_inst_rdata_hold", inst_rdata, 32'h0000_0013);

    // Conflict: data wins, fetch follows
    data_req = 1'b1; data_we = 1'b0; data_addr = 10'h010;
    inst_req = 1'b1; inst_addr = 10'h008; #1;
    chk("c0_data_gnt", data_gnt, 1);
    chk("c0_inst_gnt", inst_gnt, 0);
    cyc();
    data_req = 1'b0; #1;
    chk("c1_inst_gnt", inst_gnt, 1);
    chk("c1_data_rvalid", data_rvalid, 1);
    chk("c1_data_rdata", data_rdata, 32'hC0DE_0010);
    cyc();
    inst_req = 1'b0; #1;
    chk("c2_inst_rvalid", inst_rvalid, 1);
    chk("c2_inst_rdata", inst_rdata, 32'hC0DE_0008);
    chk("c2_data_rdata_hold", data_rdata, 32'hC0DE_0010);
    cyc();

    // Starvation: fetch forced on the fifth contended cycle
    data_req = 1'b1; data_addr = 10'h030; inst_req = 1'b1; inst_addr = 10'h00C;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("s%0d_inst_gnt", c), inst_gnt, (c == 4));
      chk($sformatf("s%0d_data_gnt", c), data_gnt, (c != 4));
      cyc();
    end
    data_req = 1'b0; inst_req = 1'b0;
    cyc();
    cyc();

    // Write then read-back of the same word
    data_req = 1'b1; data_we = 1'b1; data_addr = 10'h020; data_wdata = 32'hDEAD_BEEF; #1;
    chk("w_data_gnt", data_gnt, 1);
    chk("w_mem_we", mem_we, 1);
    chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    data_we = 1'b0; #1;
    chk("r_data_rvalid_after_write", data_rvalid, 0);
    chk("r_mem_we", mem_we, 0);
    chk("r_mem_wdata", mem_wdata, 0);
    cyc();
    data_req = 1'b0; #1;
    chk("r_data_rvalid", data_rvalid, 1);
    chk("r_data_rdata", data_rdata, 32'hDEAD_BEEF);
    cyc();

    // Reset pulsed while a fetch read is outstanding
    inst_req = 1'b1; inst_addr = 10'h004; #1;
    chk("m_inst_gnt", inst_gnt, 1);
    cyc();
    rst = 1'b1; inst_req = 1'b0; #1;
    chk("m_inst_rvalid_rst", inst_rvalid, 0);
    cyc();
    rst = 1'b0; #1;
    chk("m_inst_rvalid_rel", inst_rvalid, 0);
    chk("m_starve_cnt", dut.starve_cnt, 0);
    cyc();
    chk("m_inst_rvalid_post", inst_rvalid, 0);
    cyc();
    cyc();
    chk("sb_drain", iq.size() + dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
